can_fifo_ctrl: RTL and testbench

Parametrised synchronous FIFO for CAN frame buffering between the bus-side frame engine and the host/register interface. It generalises the fixed 128-bit CAN frame FIFO in four ways:
- configurable data width and depth, with non-power-of-two depths supported;
- occupancy count and almost-full/almost-empty watermarks;
- a synchronous flush;
- a simultaneous read and write accepted while full.

Read data is first-word-fall-through: it is presented combinationally from the head entry.

---
 rtl/can_fifo_ctrl.sv | 167 ++++++++++++++++
 tb/tb_can_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_fifo_ctrl.sv
// First-word-fall-through FIFO for CAN frame records with occupancy count, watermarks and flush.
// Optional saturating dropped-write counter on o_drop_cnt when CAN_FIFO_DROP_CNT_EN is defined.
module can_fifo_ctrl #(
    parameter int DATA_WIDTH    = 128,
    parameter int MEM_DEPTH     = 4,
    parameter int AFULL_THRESH  = MEM_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                           i_sys_clk,
    input  logic                           i_reset_n,
    input  logic                           i_flush,
    input  logic                           i_w_en,
    input  logic [DATA_WIDTH-1:0]          i_fifo_w_data,
    input  logic                           i_r_en,
    output logic [DATA_WIDTH-1:0]          o_fifo_r_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic                           o_almost_full,
    output logic                           o_almost_empty,
    output logic [$clog2(MEM_DEPTH+1)-1:0] o_count,
    output logic                           o_overflow,
`ifdef CAN_FIFO_DROP_CNT_EN
    output logic [ERR_CNT_WIDTH-1:0]       o_drop_cnt,
`endif
    output logic                           o_underflow
);

    localparam int CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int PTR_W = $clog2(MEM_DEPTH);

    generate
        if (MEM_DEPTH < 2 || MEM_DEPTH > 256) begin : g_bad_depth
            $error("can_fifo_ctrl: MEM_DEPTH %0d outside 2..256", MEM_DEPTH);
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > MEM_DEPTH) begin : g_bad_afull
            $error("can_fifo_ctrl: AFULL_THRESH %0d outside 1..MEM_DEPTH", AFULL_THRESH);
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > MEM_DEPTH - 1) begin : g_bad_aempty
            $error("can_fifo_ctrl: AEMPTY_THRESH %0d outside 0..MEM_DEPTH-1", AEMPTY_THRESH);
        end
    endgenerate

    // Explicit wrap so non-power-of-two depths index only valid entries
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(MEM_DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [PTR_W-1:0]      r_w_ptr;
    logic [PTR_W-1:0]      r_r_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_wr_reject;
    logic                  w_rd_reject;
    logic [PTR_W-1:0]      w_w_ptr_nxt;
    logic [PTR_W-1:0]      w_r_ptr_nxt;
    logic [CNT_W-1:0]      w_count_nxt;

    assign w_full  = (r_count == CNT_W'(MEM_DEPTH));
    assign w_empty = (r_count == {CNT_W{1'b0}});

    // A read frees the slot the concurrent write needs, so full with read still accepts the write
    assign w_wr_ok     = i_w_en && (!w_full || i_r_en);
    assign w_rd_ok     = i_r_en && !w_empty;
    assign w_wr_accept = w_wr_ok && !i_flush;
    assign w_rd_accept = w_rd_ok && !i_flush;
    assign w_wr_reject = i_w_en && !w_wr_ok && !i_flush;
    assign w_rd_reject = i_r_en && !w_rd_ok && !i_flush;

    // Next-state for pointers and occupancy count
    always_comb begin
        w_w_ptr_nxt = r_w_ptr;
        w_r_ptr_nxt = r_r_ptr;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_w_ptr_nxt = {PTR_W{1'b0}};
            w_r_ptr_nxt = {PTR_W{1'b0}};
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            if (w_wr_accept) begin
                w_w_ptr_nxt = ptr_inc(r_w_ptr);
            end else begin
                w_w_ptr_nxt = r_w_ptr;
            end
            if (w_rd_accept) begin
                w_r_ptr_nxt = ptr_inc(r_r_ptr);
            end else begin
                w_r_ptr_nxt = r_r_ptr;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointer, count and error-pulse registers
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_w_ptr     <= {PTR_W{1'b0}};
            r_r_ptr     <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_w_ptr     <= w_w_ptr_nxt;
            r_r_ptr     <= w_r_ptr_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_wr_reject;
            r_underflow <= w_rd_reject;
        end
    end

    // Storage array; cleared only by reset, flush leaves contents in place
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_wr_accept) begin
            r_mem[r_w_ptr] <= i_fifo_w_data;
        end
    end

`ifdef CAN_FIFO_DROP_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_drop_cnt;

    // Saturating tally of rejected writes; flush takes priority
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drop_cnt <= {ERR_CNT_WIDTH{1'b0}};
        end else if (i_flush) begin
            r_drop_cnt <= {ERR_CNT_WIDTH{1'b0}};
        end else if (w_wr_reject && (r_drop_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_fifo_r_data  = r_mem[r_r_ptr];
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= CNT_W'(AFULL_THRESH));
    assign o_almost_empty = (r_count <= CNT_W'(AEMPTY_THRESH));
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_can_fifo_ctrl.sv
// Scoreboard bench for can_fifo_ctrl: depth-4/128-bit and depth-3/16-bit instances.
module tb_can_fifo_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // depth 4 instance
    logic         d4_flush, d4_wen, d4_ren;
    logic [127:0] d4_wdata, d4_rdata;
    logic         d4_full, d4_empty, d4_afull, d4_aempty, d4_ovf, d4_unf;
    logic [2:0]   d4_count;
    // depth 3 instance
    logic         d3_flush, d3_wen, d3_ren;
    logic [15:0]  d3_wdata, d3_rdata;
    logic         d3_full, d3_empty, d3_afull, d3_aempty, d3_ovf, d3_unf;
    logic [1:0]   d3_count;
`ifdef CAN_FIFO_DROP_CNT_EN
    logic [7:0]   d4_drop, d3_drop;
`endif

    can_fifo_ctrl #(.DATA_WIDTH(128), .MEM_DEPTH(4)) u_dut4 (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_flush(d4_flush),
        .i_w_en(d4_wen), .i_fifo_w_data(d4_wdata), .i_r_en(d4_ren),
        .o_fifo_r_data(d4_rdata), .o_full(d4_full), .o_empty(d4_empty),
        .o_almost_full(d4_afull), .o_almost_empty(d4_aempty), .o_count(d4_count),
        .o_overflow(d4_ovf),
`ifdef CAN_FIFO_DROP_CNT_EN
        .o_drop_cnt(d4_drop),
`endif
        .o_underflow(d4_unf)
    );

    can_fifo_ctrl #(.DATA_WIDTH(16), .MEM_DEPTH(3)) u_dut3 (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_flush(d3_flush),
        .i_w_en(d3_wen), .i_fifo_w_data(d3_wdata), .i_r_en(d3_ren),
        .o_fifo_r_data(d3_rdata), .o_full(d3_full), .o_empty(d3_empty),
        .o_almost_full(d3_afull), .o_almost_empty(d3_aempty), .o_count(d3_count),
        .o_overflow(d3_ovf),
`ifdef CAN_FIFO_DROP_CNT_EN
        .o_drop_cnt(d3_drop),
`endif
        .o_underflow(d3_unf)
    );

    logic [127:0] q4[$];
    logic [15:0]  q3[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted read is checked against the head of the scoreboard queue
    always @(negedge clk) begin
        if (rst_n && d4_ren && !d4_empty && !d4_flush) begin
            if (q4.size() == 0) begin
                chk("d4_pop_unexpected", 128'(1), 128'(0));
            end else begin
                chk("d4_pop_data", d4_rdata, q4.pop_front());
            end
        end
        if (rst_n && d3_ren && !d3_empty && !d3_flush) begin
            if (q3.size() == 0) begin
                chk("d3_pop_unexpected", 128'(1), 128'(0));
            end else begin
                chk("d3_pop_data", 128'(d3_rdata), 128'(q3.pop_front()));
            end
        end
    end

    logic [127:0] v_a, v_b, v_c, v_d, v_e, v_f, v_x, v_y, v_z, v_w;
    logic [127:0] wr_vec [4];
    logic         exp_afull [4];

    initial begin
        v_a = {4{32'hAAAA_0001}}; v_b = {4{32'hBBBB_0002}}; v_c = {4{32'hCCCC_0003}};
        v_d = {4{32'hDDDD_0004}}; v_e = {4{32'hEEEE_0005}}; v_f = {4{32'hFFFF_0006}};
        v_x = 128'h1111; v_y = 128'h2222; v_z = 128'h3333; v_w = 128'h4444;
        wr_vec[0] = v_a; wr_vec[1] = v_b; wr_vec[2] = v_c; wr_vec[3] = v_d;
        exp_afull[0] = 1'b0; exp_afull[1] = 1'b0; exp_afull[2] = 1'b1; exp_afull[3] = 1'b1;

        d4_flush = 1'b0; d4_wen = 1'b0; d4_ren = 1'b0; d4_wdata = 128'h0;
        d3_flush = 1'b0; d3_wen = 1'b0; d3_ren = 1'b0; d3_wdata = 16'h0;
        rst_n = 1'b0;
        #3;
        chk("rst_empty", 128'(d4_empty), 128'(1));
        chk("rst_full", 128'(d4_full), 128'(0));
        chk("rst_aempty", 128'(d4_aempty), 128'(1));
        chk("rst_count", 128'(d4_count), 128'(0));
        chk("rst_rdata", d4_rdata, 128'h0);
        chk("rst_ovf_unf", 128'({d4_ovf, d4_unf}), 128'(0));
        chk("rst_d3_empty", 128'(d3_empty), 128'(1));
        tick();
        rst_n = 1'b1;
        tick();

        // Fill A..D
        for (int i = 0; i < 4; i++) begin
            d4_wen = 1'b1; d4_wdata = wr_vec[i];
            tick();
            chk("fill_count", 128'(d4_count), 128'(i + 1));
            chk("fill_afull", 128'(d4_afull), 128'(exp_afull[i]));
            chk("fill_head", d4_rdata, v_a);
        end
        d4_wen = 1'b0;
        chk("fill_full", 128'(d4_full), 128'(1));

        // Write while full, no read: dropped
        d4_wen = 1'b1; d4_wdata = v_e;
        tick();
        d4_wen = 1'b0;
        chk("drop_ovf", 128'(d4_ovf), 128'(1));
        chk("drop_count", 128'(d4_count), 128'(4));
`ifdef CAN_FIFO_DROP_CNT_EN
        chk("drop_cnt", 128'(d4_drop), 128'(1));
`endif
        tick();
        chk("drop_ovf_clear", 128'(d4_ovf), 128'(0));
        chk("drop_head", d4_rdata, v_a);

        // Full with simultaneous write and read
        d4_wen = 1'b1; d4_ren = 1'b1; d4_wdata = v_e;
        q4.push_back(v_a);
        tick();
        d4_wen = 1'b0; d4_ren = 1'b0;
        chk("wr_rd_full_count", 128'(d4_count), 128'(4));
        chk("wr_rd_full_ovf", 128'(d4_ovf), 128'(0));
        d4_ren = 1'b1;
        q4.push_back(v_b); q4.push_back(v_c); q4.push_back(v_d); q4.push_back(v_e);
        repeat (4) tick();
        d4_ren = 1'b0;
        chk("drain_empty", 128'(d4_empty), 128'(1));
        chk("drain_unf", 128'(d4_unf), 128'(0));

        // Empty with simultaneous write and read: read rejected
        d4_wen = 1'b1; d4_ren = 1'b1; d4_wdata = v_f;
        tick();
        d4_wen = 1'b0; d4_ren = 1'b0;
        chk("empty_wr_rd_unf", 128'(d4_unf), 128'(1));
        chk("empty_wr_rd_count", 128'(d4_count), 128'(1));
        chk("empty_wr_rd_head", d4_rdata, v_f);
        tick();
        chk("unf_clear", 128'(d4_unf), 128'(0));
        d4_ren = 1'b1;
        q4.push_back(v_f);
        tick();
        // continuing to read while empty keeps the pulse high
        tick();
        chk("unf_cont1", 128'(d4_unf), 128'(1));
        tick();
        d4_ren = 1'b0;
        chk("unf_cont2", 128'(d4_unf), 128'(1));
        chk("unf_count", 128'(d4_count), 128'(0));

        // Depth 3: prefill two, then 10 write/read pairs through the wrap
        d3_wen = 1'b1;
        d3_wdata = 16'h1000; tick();
        d3_wdata = 16'h1001; tick();
        d3_ren = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d3_wdata = 16'(4096 + i + 2);
            q3.push_back(16'(4096 + i));
            tick();
            chk("d3_pair_count", 128'(d3_count), 128'(2));
        end
        d3_wen = 1'b0;
        q3.push_back(16'h100A); q3.push_back(16'h100B);
        repeat (2) tick();
        d3_ren = 1'b0;
        chk("d3_drained", 128'(d3_empty), 128'(1));
        d3_wen = 1'b1;
        d3_wdata = 16'h2000; tick();
        chk("d3_afull_low", 128'(d3_afull), 128'(0));
        d3_wdata = 16'h2001; tick();
        chk("d3_afull_2", 128'(d3_afull), 128'(1));
        d3_wdata = 16'h2002; tick();
        chk("d3_full", 128'(d3_full), 128'(1));
        chk("d3_count3", 128'(d3_count), 128'(3));
        chk("d3_head", 128'(d3_rdata), 128'h2000);
        d3_wdata = 16'h2003; tick();
        d3_wen = 1'b0;
        chk("d3_ovf", 128'(d3_ovf), 128'(1));
        chk("d3_count_hold", 128'(d3_count), 128'(3));

        // Flush with a write pending at count 3
        d4_wen = 1'b1;
        d4_wdata = v_x; tick();
        d4_wdata = v_y; tick();
        d4_wdata = v_z; tick();
        chk("pre_flush_count", 128'(d4_count), 128'(3));
        d4_flush = 1'b1; d4_wdata = v_w;
        tick();
        d4_flush = 1'b0; d4_wen = 1'b0;
        chk("flush_count", 128'(d4_count), 128'(0));
        chk("flush_empty", 128'(d4_empty), 128'(1));
        chk("flush_ovf", 128'(d4_ovf), 128'(0));
        // slot 0 last held Z; flush leaves memory intact
        chk("flush_mem_kept", d4_rdata, v_z);
`ifdef CAN_FIFO_DROP_CNT_EN
        chk("flush_drop_cnt", 128'(d4_drop), 128'(0));
`endif
        d3_flush = 1'b1; d3_wen = 1'b1; d3_wdata = 16'h2004;
        tick();
        d3_flush = 1'b0; d3_wen = 1'b0;
        chk("d3_flush_count", 128'(d3_count), 128'(0));
        chk("d3_flush_ovf", 128'(d3_ovf), 128'(0));

        // Asynchronous reset between clock edges
        d4_wen = 1'b1; d4_wdata = v_w;
        tick();
        d4_wen = 1'b0;
        chk("pre_rst_count", 128'(d4_count), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 128'(d4_count), 128'(0));
        chk("async_rst_empty", 128'(d4_empty), 128'(1));
        chk("async_rst_aempty", 128'(d4_aempty), 128'(1));
        chk("async_rst_full", 128'(d4_full), 128'(0));
        chk("async_rst_rdata", d4_rdata, 128'h0);
        chk("async_rst_d3_rdata", 128'(d3_rdata), 128'h0);
        tick();

        chk("d4_sb_left", 128'(q4.size()), 128'(0));
        chk("d3_sb_left", 128'(q3.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
